// File: rtl/fir_cfg_pkg.sv
// Shared constants, FSM state type and byte-order helper for the FIR
// coefficient configuration transmitter.
package fir_cfg_pkg;

  localparam int N_COEF  = 16;
  localparam int N_BYTES = 17;
  localparam int COEF_W  = 8;
  localparam int TAP_W   = 4;

  localparam logic [4:0] ADDR_TAP = 5'd16;
  localparam logic [4:0] K_LAST   = 5'(N_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SEND,
    GAP,
    HOLD,
    FIN
  } state_t;

  // Byte 0 carries the tap count; bytes 1..16 carry h_15 down to h_0 so the
  // receiver chain ends with h_0 nearest the input.
  function automatic logic [4:0] byte_index(input logic [4:0] k);
    if (k == 5'd0) return ADDR_TAP;
    return 5'(N_COEF) - k;
  endfunction

endpackage

// File: rtl/fir_coef_image.sv
// Local coefficient/tap image with write port and read-by-index port.
// FIR_CONFIG_TX_SHADOW_EN adds a staging image copied to the active image on load.
module fir_coef_image
  import fir_cfg_pkg::*;
#(
  parameter logic [COEF_W-1:0] COEF_RST = 8'h40,
  parameter logic [TAP_W-1:0]  TAP_RST  = 4'd15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [COEF_W-1:0] wr_data,
`ifdef FIR_CONFIG_TX_SHADOW_EN
  input  logic              load,
`else
  input  logic              busy,
`endif
  input  logic [4:0]        rd_idx,
  output logic [COEF_W-1:0] rd_data
);

  logic [COEF_W-1:0] coef [N_COEF];
  logic [TAP_W-1:0]  tap;

`ifdef FIR_CONFIG_TX_SHADOW_EN
  logic [COEF_W-1:0] stg_coef     [N_COEF];
  logic [COEF_W-1:0] stg_coef_nxt [N_COEF];
  logic [TAP_W-1:0]  stg_tap;
  logic [TAP_W-1:0]  stg_tap_nxt;

  // The load copies the staging image including a write in the same cycle.
  always_comb begin
    stg_coef_nxt = stg_coef;
    stg_tap_nxt  = stg_tap;
    if (wr_en) begin
      if (wr_addr < ADDR_TAP) stg_coef_nxt[wr_addr[3:0]] = wr_data;
      else if (wr_addr == ADDR_TAP) stg_tap_nxt = wr_data[TAP_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_COEF; i++) begin
        stg_coef[i] <= COEF_RST;
        coef[i]     <= COEF_RST;
      end
      stg_tap <= TAP_RST;
      tap     <= TAP_RST;
    end else begin
      stg_coef <= stg_coef_nxt;
      stg_tap  <= stg_tap_nxt;
      if (load) begin
        coef <= stg_coef_nxt;
        tap  <= stg_tap_nxt;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_COEF; i++) coef[i] <= COEF_RST;
      tap <= TAP_RST;
    end else if (wr_en && !busy) begin
      if (wr_addr < ADDR_TAP) coef[wr_addr[3:0]] <= wr_data;
      else if (wr_addr == ADDR_TAP) tap <= wr_data[TAP_W-1:0];
    end
  end
`endif

  assign rd_data = (rd_idx == ADDR_TAP) ? {{(COEF_W-TAP_W){1'b0}}, tap} : coef[rd_idx[3:0]];

endmodule

// File: rtl/fir_config_tx.sv
// Serializes the coefficient image into the FIR config shift chain as 17 strobed bytes.
// Optional FIR_CONFIG_TX_SHADOW_EN: double-buffered image so writes never disturb a transfer.
module fir_config_tx
  import fir_cfg_pkg::*;
#(
  parameter int                PULSE_GAP = 1,
  parameter logic [COEF_W-1:0] COEF_RST  = 8'h40,
  parameter logic [TAP_W-1:0]  TAP_RST   = 4'd15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [COEF_W-1:0] wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              config_enable,
  output logic              config_data_enable,
  output logic [COEF_W-1:0] data_in
);

  localparam logic [3:0] GAP_LD = 4'(PULSE_GAP);

  state_t            state, state_nxt;
  logic [4:0]        k, k_nxt;
  logic [3:0]        gap_cnt, gap_nxt;
  logic              busy_nxt, done_nxt, ce_nxt, cde_nxt;
  logic [COEF_W-1:0] din_nxt;
  logic [4:0]        rd_idx;
  logic [COEF_W-1:0] rd_data;

  fir_coef_image #(
    .COEF_RST (COEF_RST),
    .TAP_RST  (TAP_RST)
  ) u_image (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
`ifdef FIR_CONFIG_TX_SHADOW_EN
    .load    (start && (state == IDLE)),
`else
    .busy    (busy),
`endif
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  // Outputs are computed from the next state and registered with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      k                  <= 5'd0;
      gap_cnt            <= 4'd0;
      busy               <= 1'b0;
      done               <= 1'b0;
      config_enable      <= 1'b0;
      config_data_enable <= 1'b0;
      data_in            <= '0;
    end else begin
      state              <= state_nxt;
      k                  <= k_nxt;
      gap_cnt            <= gap_nxt;
      busy               <= busy_nxt;
      done               <= done_nxt;
      config_enable      <= ce_nxt;
      config_data_enable <= cde_nxt;
      data_in            <= din_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    gap_nxt   = gap_cnt;
    case (state)
      IDLE: if (start) begin
        state_nxt = SETUP;
        k_nxt     = 5'd0;
      end
      SETUP: state_nxt = SEND;
      SEND: begin
        if (k == K_LAST) state_nxt = HOLD;
        else if (GAP_LD == 4'd0) k_nxt = k + 5'd1;
        else begin
          state_nxt = GAP;
          gap_nxt   = GAP_LD;
        end
      end
      GAP: begin
        if (gap_cnt <= 4'd1) begin
          state_nxt = SEND;
          k_nxt     = k + 5'd1;
        end else gap_nxt = gap_cnt - 4'd1;
      end
      HOLD:    state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_idx   = byte_index(k_nxt);
    busy_nxt = (state_nxt != IDLE);
    ce_nxt   = (state_nxt == SETUP) || (state_nxt == SEND) ||
               (state_nxt == GAP) || (state_nxt == HOLD);
    cde_nxt  = (state_nxt == SEND);
    done_nxt = (state_nxt == FIN);
    din_nxt  = cde_nxt ? rd_data : '0;
  end

endmodule

// File: tb/tb_fir_config_tx.sv
// Directed bench for fir_config_tx: two instances (PULSE_GAP=1 and 0) share
// inputs; a receiver shift-chain model rebuilds the coefficients from the strobes.
module tb_fir_config_tx;

  logic       clk, rst, wr_en, start;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;

  // index 0: PULSE_GAP=0 instance, index 1: PULSE_GAP=1 instance
  logic       bsy [2];
  logic       dn  [2];
  logic       ce  [2];
  logic       cde [2];
  logic [7:0] din [2];

  fir_config_tx #(.PULSE_GAP(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(bsy[0]), .done(dn[0]), .config_enable(ce[0]),
    .config_data_enable(cde[0]), .data_in(din[0])
  );

  fir_config_tx #(.PULSE_GAP(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(bsy[1]), .done(dn[1]), .config_enable(ce[1]),
    .config_data_enable(cde[1]), .data_in(din[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  int         npulse   [2];
  int         pcyc     [2][32];
  logic [7:0] pbyte    [2][32];
  int         ndone    [2];
  int         done_cyc [2];
  int         ce_first [2];
  int         ce_last  [2];
  int         gap_nz   [2];
  logic       busyv    [2][46];
  logic [7:0] rx       [2][17];

  typedef struct {
    int d;
    int first;
    int step;
    int n;
    int done;
    int ce_last;
  } tv_t;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
    int         idx;
    logic [7:0] exp;
  } wv_t;

  tv_t tvec [2];
  wv_t wvec [18];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic write_img(input logic [4:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick;
    wr_en = 1'b0;
  endtask

  // Start a transfer and observe 45 cycles; inj_kind 1 = write, 2 = start,
  // applied during cycle inj_cyc (cycle 0 = together with the start).
  task automatic apply_stimulus(input int inj_kind, input int inj_cyc,
                                input logic [4:0] ia, input logic [7:0] id);
    for (int d = 0; d < 2; d++) begin
      npulse[d] = 0; ndone[d] = 0; done_cyc[d] = -1;
      ce_first[d] = -1; ce_last[d] = -1; gap_nz[d] = 0;
      for (int i = 0; i < 17; i++) rx[d][i] = 8'h00;
    end
    start = 1'b1;
    if (inj_kind == 1 && inj_cyc == 0) begin
      wr_en = 1'b1; wr_addr = ia; wr_data = id;
    end
    tick;
    start = 1'b0; wr_en = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      for (int d = 0; d < 2; d++) begin
        busyv[d][c] = bsy[d];
        if (ce[d]) begin
          if (ce_first[d] < 0) ce_first[d] = c;
          ce_last[d] = c;
        end
        if (cde[d]) begin
          if (npulse[d] < 32) begin
            pcyc[d][npulse[d]]  = c;
            pbyte[d][npulse[d]] = din[d];
          end
          npulse[d]++;
          if (ce[d]) begin
            for (int i = 16; i > 0; i--) rx[d][i] = rx[d][i-1];
            rx[d][0] = din[d];
          end
        end else if (din[d] != 8'h00) gap_nz[d]++;
        if (dn[d]) begin
          ndone[d]++;
          done_cyc[d] = c;
        end
      end
      if (c == inj_cyc && inj_kind == 1) begin
        wr_en = 1'b1; wr_addr = ia; wr_data = id;
      end
      if (c == inj_cyc && inj_kind == 2) start = 1'b1;
      tick;
      start = 1'b0; wr_en = 1'b0;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check_output($sformatf("%s busy[%0d]", tag, d), 32'(bsy[d]), 0);
      check_output($sformatf("%s done[%0d]", tag, d), 32'(dn[d]), 0);
      check_output($sformatf("%s cfg_en[%0d]", tag, d), 32'(ce[d]), 0);
      check_output($sformatf("%s cfg_den[%0d]", tag, d), 32'(cde[d]), 0);
      check_output($sformatf("%s data_in[%0d]", tag, d), 32'(din[d]), 0);
    end
  endtask

  task automatic check_default_image(input string tag);
    for (int d = 0; d < 2; d++) begin
      check_output($sformatf("%s pulses[%0d]", tag, d), npulse[d], 17);
      check_output($sformatf("%s tap[%0d]", tag, d), 32'(rx[d][16]), 32'h0F);
      for (int i = 0; i < 16; i++)
        check_output($sformatf("%s h%0d[%0d]", tag, i, d), 32'(rx[d][i]), 32'h40);
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 8'h00; start = 1'b0;

    tvec[0] = '{d: 1, first: 2, step: 2, n: 17, done: 36, ce_last: 35};
    tvec[1] = '{d: 0, first: 2, step: 1, n: 17, done: 20, ce_last: 19};

    for (int i = 0; i < 16; i++)
      wvec[i] = '{addr: 5'(i), data: 8'(8'h10 + i), idx: i, exp: 8'(8'h10 + i)};
    wvec[16] = '{addr: 5'd16, data: 8'hA7, idx: 16, exp: 8'h07};
    wvec[17] = '{addr: 5'd20, data: 8'hEE, idx: 16, exp: 8'h07};

    tick; tick;
    check_idle_outputs("reset");
    rst = 1'b0;
    tick;

    // Default image, timing for both gap settings
    apply_stimulus(0, -1, 5'd0, 8'h00);
    foreach (tvec[t]) begin
      int d;
      d = tvec[t].d;
      check_output($sformatf("pulses[%0d]", d), npulse[d], tvec[t].n);
      for (int k = 0; k < 17; k++) begin
        check_output($sformatf("pulse%0d cyc[%0d]", k, d), pcyc[d][k], tvec[t].first + k * tvec[t].step);
        check_output($sformatf("pulse%0d byte[%0d]", k, d), 32'(pbyte[d][k]), (k == 0) ? 32'h0F : 32'h40);
      end
      check_output($sformatf("done count[%0d]", d), ndone[d], 1);
      check_output($sformatf("done cyc[%0d]", d), done_cyc[d], tvec[t].done);
      check_output($sformatf("cfg_en first[%0d]", d), ce_first[d], 1);
      check_output($sformatf("cfg_en last[%0d]", d), ce_last[d], tvec[t].ce_last);
      check_output($sformatf("gap data[%0d]", d), gap_nz[d], 0);
      begin
        int hi;
        hi = 0;
        for (int c = 1; c < tvec[t].done; c++) if (busyv[d][c] === 1'b1) hi++;
        check_output($sformatf("busy window[%0d]", d), hi, tvec[t].done - 1);
      end
      check_output($sformatf("busy after[%0d]", d), 32'(busyv[d][tvec[t].done + 1]), 0);
    end

    // Image writes via table, then receiver reconstruction
    foreach (wvec[i]) write_img(wvec[i].addr, wvec[i].data);
    apply_stimulus(0, -1, 5'd0, 8'h00);
    for (int d = 0; d < 2; d++)
      foreach (wvec[i])
        check_output($sformatf("rx slot%0d vec%0d[%0d]", wvec[i].idx, i, d),
                     32'(rx[d][wvec[i].idx]), 32'(wvec[i].exp));

    // start while busy ignored
    apply_stimulus(2, 10, 5'd0, 8'h00);
    for (int d = 0; d < 2; d++) begin
      check_output($sformatf("restart pulses[%0d]", d), npulse[d], 17);
      check_output($sformatf("restart dones[%0d]", d), ndone[d], 1);
      check_output($sformatf("restart idle end[%0d]", d), 32'(busyv[d][45]), 0);
    end

    // write h_3 during transfer
    apply_stimulus(1, 8, 5'd3, 8'hAA);
    for (int d = 0; d < 2; d++)
      check_output($sformatf("busy write now h3[%0d]", d), 32'(rx[d][3]), 32'h13);
    apply_stimulus(0, -1, 5'd0, 8'h00);
    for (int d = 0; d < 2; d++) begin
`ifdef FIR_CONFIG_TX_SHADOW_EN
      check_output($sformatf("busy write next h3[%0d]", d), 32'(rx[d][3]), 32'hAA);
`else
      check_output($sformatf("busy write next h3[%0d]", d), 32'(rx[d][3]), 32'h13);
`endif
      check_output($sformatf("busy write next h4[%0d]", d), 32'(rx[d][4]), 32'h14);
    end

    // write together with start lands first
    apply_stimulus(1, 0, 5'd5, 8'h5A);
    for (int d = 0; d < 2; d++)
      check_output($sformatf("same-cycle write h5[%0d]", d), 32'(rx[d][5]), 32'h5A);

    // reset during cycle 12 of a transfer
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c < 12; c++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_idle_outputs("mid reset");
    tick;
    apply_stimulus(0, -1, 5'd0, 8'h00);
    check_default_image("after reset");
    check_output("after reset done1", done_cyc[1], 36);
    check_output("after reset done0", done_cyc[0], 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
